// File: rtl/clock_pkg.sv
// Shared definitions for the clock/chime blocks: FSM encoding, strike limits
// and the hour-to-strike mapping used by hourly_chime.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEEP = 2'd1,
    ST_GAP  = 2'd2
  } chime_state_e;

  localparam int unsigned MAX_STRIKES = 12;
  localparam int unsigned HOURS_W     = 5;

  // 12-hour dial: 0 and 12 strike twelve; out-of-range hours strike once.
  function automatic logic [3:0] strike_count(input logic [HOURS_W-1:0] hours);
    logic [HOURS_W-1:0] h;
    if (hours >= HOURS_W'(24)) return 4'd1;
    h = hours;
    if (h >= HOURS_W'(12)) h = h - HOURS_W'(12);
    if (h == '0) return 4'(MAX_STRIKES);
    return h[3:0];
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles every TONE_HALF enabled cycles,
// clr forces count and output back to 0.
module tone_gen #(
  parameter int unsigned TONE_HALF = 12500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tone
);

  localparam int unsigned    CW   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [CW-1:0]  TERM = CW'(TONE_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clr) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/hourly_chime.sv
// Hourly chime player: synchronises the 1 Hz play_sound trigger and strikes the
// hour on the buzzer. Define CHIME_STRIKE_COUNT_EN to strike per hour; else one beep.
module hourly_chime
  import clock_pkg::*;
#(
  parameter int unsigned TONE_HALF   = 12500,
  parameter int unsigned BEEP_CYCLES = 10_000_000,
  parameter int unsigned GAP_CYCLES  = 15_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               play_sound,
  input  logic [HOURS_W-1:0] hours,
  input  logic               mute,
  output logic               buzzer,
  output logic               busy,
  output logic               done
);

  localparam int unsigned   MAXC      = (BEEP_CYCLES > GAP_CYCLES) ? BEEP_CYCLES : GAP_CYCLES;
  localparam int unsigned   PH_W      = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [PH_W-1:0] BEEP_TERM = PH_W'(BEEP_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_TERM  = PH_W'(GAP_CYCLES - 1);

  logic            sync1_q, sync2_q, prev_q, trig_q;
  logic [1:0]      warm_q;
  chime_state_e    state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            done_q, done_d;
  logic            buzzer_q, buzzer_d;
  logic            tone, tone_clr;

  // prev_q starts high and only tracks sync2_q once the synchroniser holds a
  // real sample, so a level already high at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      warm_q  <= '0;
      prev_q  <= 1'b1;
      trig_q  <= 1'b0;
    end else begin
      sync1_q <= play_sound;
      sync2_q <= sync1_q;
      warm_q  <= {warm_q[0], 1'b1};
      if (warm_q[1]) prev_q <= sync2_q;
      trig_q  <= warm_q[1] & sync2_q & ~prev_q;
    end
  end

`ifdef CHIME_STRIKE_COUNT_EN
  logic [3:0] strikes_left_q, strikes_left_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) strikes_left_q <= '0;
    else        strikes_left_q <= strikes_left_d;
  end
`else
  logic unused_hours;
  assign unused_hours = ^hours;
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    done_d   = 1'b0;
    tone_clr = 1'b0;
`ifdef CHIME_STRIKE_COUNT_EN
    strikes_left_d = strikes_left_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (trig_q) begin
`ifdef CHIME_STRIKE_COUNT_EN
          strikes_left_d = strike_count(hours);
`endif
          phase_d  = '0;
          state_d  = ST_BEEP;
          tone_clr = 1'b1;
        end
      end
      ST_BEEP: begin
        if (phase_q == BEEP_TERM) begin
          phase_d = '0;
`ifdef CHIME_STRIKE_COUNT_EN
          strikes_left_d = strikes_left_q - 4'd1;
          if (strikes_left_q == 4'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_GAP: begin
        if (phase_q == GAP_TERM) begin
          phase_d  = '0;
          state_d  = ST_BEEP;
          tone_clr = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Gate on both sides of the register so the last beep sample never leaks into a gap.
    buzzer_d = tone & ~mute & (state_q == ST_BEEP) & (state_d == ST_BEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      done_q   <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      done_q   <= done_d;
      buzzer_q <= buzzer_d;
    end
  end

  tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == ST_BEEP),
    .clr  (tone_clr),
    .tone (tone)
  );

  assign buzzer = buzzer_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_hourly_chime.sv
// Scoreboard bench for hourly_chime: stimulus queues expected sequences, a
// negedge monitor checks busy length, done alignment and the buzzer waveform.
module tb_hourly_chime;

  localparam int TH = 2;
  localparam int B  = 8;
  localparam int G  = 4;
`ifdef CHIME_STRIKE_COUNT_EN
  localparam int ABORT_POS = 14;
`else
  localparam int ABORT_POS = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       play_sound;
  logic [4:0] hours;
  logic       mute;
  logic       buzzer, busy, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int len;
    bit muted;
    bit abort_ok;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   in_seq   = 1'b0;
  int   pos      = 0;
  int   seq_err  = 0;
  int   idle_err = 0;

  hourly_chime #(
    .TONE_HALF  (TH),
    .BEEP_CYCLES(B),
    .GAP_CYCLES (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .play_sound(play_sound),
    .hours     (hours),
    .mute      (mute),
    .buzzer    (buzzer),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic exp_buzzer(input int p, input bit m);
    int off;
    off = p % (B + G);
    if (m || off >= B || off < 1) return 1'b0;
    return logic'(((off - 1) / TH) % 2);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      if (in_seq) begin
        checks++;
        if (!cur.abort_ok) begin
          failures++;
          $display("FAIL abort: sequence cut by reset at pos %0d, expected full length %0d", pos, cur.len);
        end
        in_seq = 1'b0;
      end
    end else begin
      if (busy && !in_seq) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_seq: busy rose with no sequence expected");
          cur = '{-1, 1'b0, 1'b0};
        end else begin
          cur = q.pop_front();
        end
        in_seq  = 1'b1;
        pos     = 0;
        seq_err = 0;
      end
      if (in_seq) begin
        if (busy) begin
          if (buzzer !== exp_buzzer(pos, cur.muted) || done !== 1'b0) begin
            if (seq_err == 0)
              $display("  pos %0d: buzzer=%b done=%b", pos, buzzer, done);
            seq_err++;
          end
          pos++;
        end else begin
          checks++;
          if (pos != cur.len) begin
            failures++;
            $display("FAIL seq_len: busy lasted %0d cycles, required %0d", pos, cur.len);
          end
          checks++;
          if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_align: done=%b when busy fell, required 1", done);
          end
          checks++;
          if (seq_err != 0) begin
            failures++;
            $display("FAIL buzzer_wave: %0d bad cycles in sequence (muted=%0d), required 0", seq_err, cur.muted);
          end
          if (buzzer !== 1'b0) idle_err++;
          in_seq = 1'b0;
        end
      end else if (buzzer !== 1'b0 || done !== 1'b0) begin
        idle_err++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string tag);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n++;
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || n != 4) begin
      failures++;
      $display("FAIL latency %s: busy after %0d edges (seen=%0d), required 4", tag, n, seen);
    end
  endtask

  task automatic run_seq(input logic [4:0] h, input logic m, input int len, input bit retrig);
    bit seen;
    q.push_back('{len, m, 1'b0});
    hours      = h;
    mute       = m;
    play_sound = 1'b1;
    wait_busy($sformatf("h=%0d", h));
    seen = 1'b0;
    for (int t = 0; t < len + 40; t++) begin
      tick();
      if (t == 1) play_sound = 1'b0;
      if (retrig && t == 3) play_sound = 1'b1;
      if (retrig && t == 6) play_sound = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout h=%0d: no done within %0d cycles", h, len + 40);
    end
    play_sound = 1'b0;
    repeat (4) tick();
    mute = 1'b0;
  endtask

  // Hand-computed sequence lengths k*8 + (k-1)*4; default build always 1 beep = 8.
  localparam int NV = 9;
  logic [4:0] vh   [NV] = '{5'd3, 5'd0, 5'd12, 5'd13, 5'd5, 5'd23, 5'd24, 5'd2, 5'd2};
  bit         vm   [NV] = '{1'b0, 1'b0, 1'b0,  1'b0,  1'b0, 1'b0,  1'b0,  1'b0, 1'b1};
`ifdef CHIME_STRIKE_COUNT_EN
  int         vlen [NV] = '{32,   140,  140,   8,     56,   128,   8,     20,   20};
  localparam int RETRIG_LEN = 32;
`else
  int         vlen [NV] = '{8,    8,    8,     8,     8,    8,     8,     8,    8};
  localparam int RETRIG_LEN = 8;
`endif

  initial begin
    int nb;
    rst_n      = 1'b0;
    play_sound = 1'b0;
    hours      = '0;
    mute       = 1'b0;
    repeat (3) tick();
    checks += 3;
    if (buzzer !== 1'b0) begin failures++; $display("FAIL rst_buzzer: got %b, required 0", buzzer); end
    if (busy   !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done   !== 1'b0) begin failures++; $display("FAIL rst_done: got %b, required 0", done); end
    rst_n = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < NV; i++) run_seq(vh[i], vm[i], vlen[i], 1'b0);

    run_seq(5'd3, 1'b0, RETRIG_LEN, 1'b1);
    run_seq(5'd3, 1'b0, RETRIG_LEN, 1'b0);

    q.push_back('{-1, 1'b0, 1'b1});
    hours      = 5'd3;
    play_sound = 1'b1;
    wait_busy("abort");
    repeat (ABORT_POS) tick();
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (buzzer !== 1'b0) begin failures++; $display("FAIL abort_buzzer: got %b, required 0", buzzer); end
    if (busy   !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b, required 0", busy); end
    if (done   !== 1'b0) begin failures++; $display("FAIL abort_done: got %b, required 0", done); end
    repeat (3) tick();
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) nb++;
    end
    checks++;
    if (nb != 0) begin
      failures++;
      $display("FAIL held_after_reset: busy for %0d cycles with play_sound held, required 0", nb);
    end
    play_sound = 1'b0;
    repeat (4) tick();
    run_seq(5'd1, 1'b0, 8, 1'b0);

    repeat (4) tick();
    checks++;
    if (idle_err != 0) begin
      failures++;
      $display("FAIL idle_outputs: %0d idle cycles with buzzer/done high, required 0", idle_err);
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: %0d expected sequences never seen, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/hourly_chime.md
# hourly_chime

Hourly chime player: consumes the clock core's `play_sound` trigger and `hours` value and drives a piezo buzzer with a strike sequence, one beep per hour on a 12-hour dial. Runs on the fast system clock. Treats `play_sound` and `hours` as asynchronous inputs from the 1 Hz timekeeping domain. Sits between the timekeeping core and the board buzzer pin.

## Interface
- `TONE_HALF`, default 12500: system-clock cycles per buzzer half-period (50 MHz → 2 kHz tone).
- `BEEP_CYCLES`, default 10_000_000: length of one beep in cycles (200 ms).
- `GAP_CYCLES`, default 15_000_000: silence between beeps in cycles (300 ms).
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous active-low reset.
- `play_sound  in  1`: chime trigger, level from the 1 Hz domain; the rising edge starts a sequence.
- `hours  in  5`: current hour, 0–23; stable for ≥1 s around the trigger.
- `mute  in  1`: silences the buzzer without altering sequence timing.
- `buzzer  out  1`: square-wave drive.
- `busy  out  1`: high while a sequence runs.
- `done  out  1`: one-cycle pulse at sequence end.

## Operation
- `play_sound` passes a 2-FF synchronizer, then a registered edge detector produces `trig`, a one-cycle pulse.
- Strike count is computed from `hours` sampled on the `trig` cycle:
  - h = hours mod 12, with 0 mapped to 12.
  - hours ≥ 24 is invalid and gives 1 strike.
  - Examples: 0→12, 1→1, 13→1, 12→12, 23→11.
- FSM states: IDLE, BEEP, GAP.
  - IDLE: on `trig`, latch the strike count into `strikes_left`, clear the phase counter, and go to BEEP.
  - BEEP: run for BEEP_CYCLES cycles, then decrement `strikes_left`.
    - If the result is 0: go to IDLE and pulse `done`.
    - Otherwise: go to GAP.
  - GAP: run for GAP_CYCLES cycles, then go to BEEP.
  - No trailing gap after the last beep.
- `busy` = (state != IDLE).
- `trig` while busy is ignored. There is no queueing.
- Tone generator:
  - Free-runs only in BEEP.
  - Reset to count 0 and output 0 on every BEEP entry.
  - Output toggles every TONE_HALF cycles.
- `buzzer` = tone output & ~mute, registered. It is 0 in IDLE and GAP.
- `mute` has no effect on state, counters, `busy` or `done`.
- Counter widths:
  - Phase counter: $clog2(max(BEEP_CYCLES, GAP_CYCLES)).
  - Strike counter: 4 bits.
  - All counters saturate-free; the terminal count is compared exactly.
- Reset values: `buzzer`=0, `busy`=0, `done`=0, state IDLE, synchronizer flops 0.
  - Reset mid-sequence aborts immediately.
  - If `play_sound` is already high on reset release, a sequence starts only after `play_sound` falls and rises again.

## Timing
- `play_sound` rising before clk edge N produces `trig` in cycle N+2, with `busy` high from cycle N+3.
- Each BEEP lasts exactly BEEP_CYCLES cycles; each GAP exactly GAP_CYCLES cycles.
- First `buzzer` rise occurs TONE_HALF cycles after BEEP entry, +1 cycle for the output register.
- `done` is asserted in the cycle IDLE is re-entered, coincident with `busy` falling.
- Sequence length for k strikes: k·BEEP_CYCLES + (k−1)·GAP_CYCLES cycles.

## Configuration
- `CHIME_STRIKE_COUNT_EN`:
  - Defined: strike count follows `hours` as above.
  - Undefined: every trigger produces exactly one beep; `hours` is unused and the strike counter is removed.

## Structure
- Shared package `clock_pkg`:
  - FSM state encoding (IDLE=0, BEEP=1, GAP=2).
  - `MAX_STRIKES`=12.
  - `HOURS_W`=5.
- Sub-module `tone_gen`:
  - Parameter TONE_HALF.
  - Inputs clk, rst_n, en, clr; output `tone`.
  - Reused by the alarm block.
- Synchronizer and FSM stay inline.

## Test plan
All scenarios use TONE_HALF=2, BEEP_CYCLES=8, GAP_CYCLES=4.
- hours=3, pulse `play_sound` → three 8-cycle beeps separated by 4-cycle gaps. `busy` high for 32 cycles, then a single `done` pulse.
- hours=0 → 12 beeps; hours=12 → 12 beeps; hours=13 → 1 beep. With the macro undefined, hours=5 → 1 beep.
- During a beep, `buzzer` toggles every 2 cycles starting low; `buzzer` is 0 throughout gaps and IDLE.
- `mute`=1 with hours=2 → `buzzer` stuck at 0 while `busy` and `done` timing match the unmuted run.
- Second `play_sound` edge mid-sequence → ignored, and the sequence length is unchanged. A new edge after `done` → new sequence.
- `rst_n` low during the second beep → `buzzer`, `busy`, `done` all 0 immediately. No sequence after release while `play_sound` stays high.
